// File: rtl/snake_pkg.sv
// Shared types and constants for the snake motion controller.
package snake_pkg;

    localparam int unsigned COORD_W    = 6;
    localparam int unsigned GRID_W_DEF = 50;
    localparam int unsigned GRID_H_DEF = 50;

    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;

    // Opposite directions differ in both bits, so a reversal is (a ^ b) == 2'b11
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Returns {hit, dir}; hit=0 for codes that are not arrow keys
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        logic [2:0] res;
        case (code)
            KC_UP:    res = {1'b1, DIR_UP};
            KC_RIGHT: res = {1'b1, DIR_RIGHT};
            KC_DOWN:  res = {1'b1, DIR_DOWN};
            KC_LEFT:  res = {1'b1, DIR_LEFT};
            default:  res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-rate divider: counts enabled cycles 0..TICK_DIV-1, holds when disabled,
// and flags the terminal count combinationally so the next edge can move the head.
module snake_tick_div #(
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and terminal flag
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake motion controller: arrow-key direction buffer with reversal rejection,
// move-rate divider and head stepping with wall detection.
// Build option: define SNAKE_WALL_WRAP_EN to wrap the head around the playfield
// edges instead of dying on a wall hit.
module snake_motion_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF,
    parameter int unsigned TICK_DIV = 5_000_000,
    parameter int unsigned START_X  = 25,
    parameter int unsigned START_Y  = 25
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [7:0]           key_code,
    input  logic                 key_valid,
    input  logic                 enable,
    output logic [COORD_W-1:0]   head_x,
    output logic [COORD_W-1:0]   head_y,
    output logic [1:0]           direction,
    output logic                 step,
    output logic                 dead
);

    localparam int unsigned SW = COORD_W + 1;
    localparam logic signed [SW-1:0] GRID_W_S = SW'(GRID_W);
    localparam logic signed [SW-1:0] GRID_H_S = SW'(GRID_H);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);

    state_t               state_q, state_d;
    dir_t                 pending_q, pending_d;
    dir_t                 direction_q, direction_d;
    logic [COORD_W-1:0]   head_x_q, head_x_d;
    logic [COORD_W-1:0]   head_y_q, head_y_d;
    logic                 step_q, step_d;
    logic                 dead_q, dead_d;

    logic                 tick_c;
    logic                 div_en_c;
    logic signed [SW-1:0] nx, ny;
    logic                 x_oob, y_oob, hit;
    logic [2:0]           key_dec;

    assign div_en_c = (state_q == ST_RUN) && enable;

    snake_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (CLOCK_50),
        .rst    (RESET),
        .en     (div_en_c),
        .tick_c (tick_c)
    );

    // Candidate head from the buffered direction, wall check and optional wrap
    always_comb begin
        nx = $signed({1'b0, head_x_q});
        ny = $signed({1'b0, head_y_q});
        case (pending_q)
            DIR_UP:    ny = ny - ONE_S;
            DIR_RIGHT: nx = nx + ONE_S;
            DIR_DOWN:  ny = ny + ONE_S;
            default:   nx = nx - ONE_S;
        endcase
        x_oob = nx[SW-1] || (nx >= GRID_W_S);
        y_oob = ny[SW-1] || (ny >= GRID_H_S);
`ifdef SNAKE_WALL_WRAP_EN
        if (nx[SW-1])  nx = GRID_W_S - ONE_S;
        else if (x_oob) nx = '0;
        if (ny[SW-1])  ny = GRID_H_S - ONE_S;
        else if (y_oob) ny = '0;
        hit = 1'b0;
`else
        hit = x_oob || y_oob;
`endif
    end

    // FSM, move commit and direction buffer update
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        direction_d = direction_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        step_d      = 1'b0;
        dead_d      = dead_q;
        key_dec     = decode_key(key_code);

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick_c) begin
                    if (hit) begin
                        dead_d  = 1'b1;
                        state_d = ST_DEAD;
                    end else begin
                        head_x_d    = COORD_W'(nx);
                        head_y_d    = COORD_W'(ny);
                        direction_d = pending_q;
                        step_d      = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A key in the step cycle is judged against the direction being committed
        if (key_valid && key_dec[2] && (state_q != ST_DEAD) &&
            ((key_dec[1:0] ^ direction_d) != 2'b11)) begin
            pending_d = dir_t'(key_dec[1:0]);
        end
    end

    // State registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            pending_q   <= DIR_UP;
            direction_q <= DIR_UP;
            head_x_q    <= COORD_W'(START_X);
            head_y_q    <= COORD_W'(START_Y);
            step_q      <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            direction_q <= direction_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            step_q      <= step_d;
            dead_q      <= dead_d;
        end
    end

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign direction = direction_q;
    assign step      = step_q;
    assign dead      = dead_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Scoreboard bench for snake_motion_ctrl with a behavioural motion model.
module tb_snake_motion_ctrl;

    localparam int TD = 4;
    localparam int GW = 50;
    localparam int GH = 50;
    localparam int SX = 25;
    localparam int SY = 25;

    logic       clk;
    logic       rst;
    logic [7:0] kc;
    logic       kv;
    logic       en;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [1:0] direction;
    logic       step;
    logic       dead;

    snake_motion_ctrl #(
        .GRID_W   (GW),
        .GRID_H   (GH),
        .TICK_DIV (TD),
        .START_X  (SX),
        .START_Y  (SY)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .key_code  (kc),
        .key_valid (kv),
        .enable    (en),
        .head_x    (head_x),
        .head_y    (head_y),
        .direction (direction),
        .step      (step),
        .dead      (dead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Model: directions indexed up, right, down, left; opposite = index + 2
    int         dx [4] = '{0, 1, 0, -1};
    int         dy [4] = '{-1, 0, 1, 0};
    int         enc[4] = '{0, 1, 3, 2};
    int         m_state;    // 0 idle, 1 run, 2 dead
    int         m_since;
    int         m_pend, m_dir, m_x, m_y;

    typedef struct {
        int cyc;
        int x;
        int y;
        int dir;
        bit death;
    } ev_t;
    ev_t q[$];

    function automatic int decode(input logic [7:0] c);
        case (c)
            8'h75:   return 0;
            8'h74:   return 1;
            8'h72:   return 2;
            8'h6B:   return 3;
            default: return -1;
        endcase
    endfunction

    // Advance the model by the edge that follows the given inputs
    task automatic model(input bit r, input bit e, input bit k, input logic [7:0] code);
        int  kd, nx, ny;
        bit  wall, was_dead;
        ev_t ev;
        if (r) begin
            m_state = 0; m_since = 0; m_pend = 0; m_dir = 0; m_x = SX; m_y = SY;
            return;
        end
        was_dead = (m_state == 2);
        if (m_state == 0) begin
            if (e) m_state = 1;
        end else if (m_state == 1 && e) begin
            m_since++;
            if (m_since == TD) begin
                m_since = 0;
                nx = m_x + dx[m_pend];
                ny = m_y + dy[m_pend];
                wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WALL_WRAP_EN
                if (wall) begin
                    nx = (nx + GW) % GW;
                    ny = (ny + GH) % GH;
                    wall = 1'b0;
                end
`endif
                ev.cyc = cyc_n + 1;
                if (wall) begin
                    m_state = 2;
                    ev.death = 1'b1;
                end else begin
                    m_x = nx; m_y = ny; m_dir = m_pend;
                    ev.death = 1'b0;
                end
                ev.x = m_x; ev.y = m_y; ev.dir = m_dir;
                q.push_back(ev);
            end
        end
        kd = decode(code);
        if (!was_dead && k && kd >= 0 && kd != (m_dir + 2) % 4) m_pend = kd;
    endtask

    // Drive one cycle of inputs, update the model, land #1 after the edge
    task automatic cyc(input bit r, input bit e, input bit k, input logic [7:0] code);
        rst = r; en = e; kv = k; kc = code;
        model(r, e, k, code);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_since(input int v);
        int i;
        for (i = 0; i < 40; i++) begin
            if (m_state == 1 && m_since == v) break;
            cyc(0, 1, 0, 8'h00);
        end
        if (i == 40) begin
            n_vec++; n_miss++;
            $display("FAIL sync_timeout: got since %0d expected %0d", m_since, v);
        end
    endtask

    // Monitor: every step / wall hit the DUT shows must match the next queued event
    logic dead_prev = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if (step) begin
            if (q.size() == 0) begin
                chk("unexpected_step", 1, 0);
            end else begin
                ev = q.pop_front();
                chk("step_is_move", int'(ev.death), 0);
                chk("step_cycle", cyc_n, ev.cyc);
                chk("step_x", int'(head_x), ev.x);
                chk("step_y", int'(head_y), ev.y);
                chk("step_dir", int'(direction), enc[ev.dir]);
            end
        end
        if (dead && !dead_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_dead", 1, 0);
            end else begin
                ev = q.pop_front();
                chk("dead_is_hit", int'(ev.death), 1);
                chk("dead_cycle", cyc_n, ev.cyc);
                chk("dead_x", int'(head_x), ev.x);
                chk("dead_y", int'(head_y), ev.y);
                chk("dead_no_step", int'(step), 0);
            end
        end
        dead_prev <= dead;
    end

    initial begin
        int seen[$];
        int first;
        rst = 1'b1; en = 1'b0; kv = 1'b0; kc = 8'h00;
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("rst_x", int'(head_x), 25);
        chk("rst_y", int'(head_y), 25);
        chk("rst_dir", int'(direction), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_dead", int'(dead), 0);

        // Free run upward: steps 4, 8, 12 cycles after entering RUN
        for (int i = 0; i < 13; i++) begin
            cyc(0, 1, 0, 8'h00);
            if (step) seen.push_back(i);
        end
        chk("a_nsteps", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("a_step0", seen[0], 4);
            chk("a_step1", seen[1], 8);
            chk("a_step2", seen[2], 12);
        end
        chk("a_y", int'(head_y), 22);
        chk("a_x", int'(head_x), 25);

        // Reversal dropped, then a right turn commits
        run_until_since(1);
        cyc(0, 1, 1, 8'h72);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 1, 8'h74);
        for (int i = 0; i < TD; i++) cyc(0, 1, 0, 8'h00);
        chk("b_x", int'(head_x), 26);
        chk("b_dir", int'(direction), 1);

        // Two keys between steps: the last accepted one wins
        cyc(0, 1, 1, 8'h75);
        for (int i = 0; i < 2 * TD; i++) cyc(0, 1, 0, 8'h00);
        run_until_since(0);
        cyc(0, 1, 1, 8'h6B);
        cyc(0, 1, 1, 8'h74);
        for (int i = 0; i < TD; i++) cyc(0, 1, 0, 8'h00);
        chk("c_dir", int'(direction), 1);

        // Key on the step edge is judged against the newly committed direction
        run_until_since(1);
        cyc(0, 1, 1, 8'h75);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 1, 8'h72);
        for (int i = 0; i < 2 * TD; i++) cyc(0, 1, 0, 8'h00);
        chk("d_dir", int'(direction), 0);

        // Pause at divider=2: no step, then step two cycles after resuming
        run_until_since(2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h00);
        first = -1;
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0, 8'h00);
            if (step && first < 0) first = i;
        end
        chk("e_resume", first, 2);

        // Reset one cycle before a step
        run_until_since(TD - 1);
        cyc(1, 1, 0, 8'h00);
        chk("g_step", int'(step), 0);
        chk("g_x", int'(head_x), 25);
        chk("g_y", int'(head_y), 25);
        chk("g_dir", int'(direction), 0);
        chk("g_dead", int'(dead), 0);

        // Run upward into the top wall
        for (int i = 0; i < 110; i++) cyc(0, 1, 0, 8'h00);
`ifdef SNAKE_WALL_WRAP_EN
        chk("f_dead", int'(dead), 0);
`else
        chk("f_dead", int'(dead), 1);
        chk("f_y", int'(head_y), 0);
        chk("f_x", int'(head_x), 25);
        cyc(0, 1, 1, 8'h74);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h00);
        chk("f_hold_dead", int'(dead), 1);
        chk("f_hold_x", int'(head_x), 25);
        chk("f_hold_y", int'(head_y), 0);
`endif

        // Random keys, pauses and occasional resets
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            bit         r, e, k;
            logic [7:0] code;
            int         pick;
            r = ($urandom_range(0, 999) < 3);
            e = ($urandom_range(0, 99) < 85);
            k = ($urandom_range(0, 99) < 30);
            pick = $urandom_range(0, 4);
            case (pick)
                0:       code = 8'h75;
                1:       code = 8'h74;
                2:       code = 8'h72;
                3:       code = 8'h6B;
                default: code = 8'($urandom);
            endcase
            cyc(r, e, k, code);
            if (i % 16 == 15) begin
                chk("r_x", int'(head_x), m_x);
                chk("r_y", int'(head_y), m_y);
                chk("r_dead", int'(dead), int'(m_state == 2));
            end
        end

        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
